// File: rtl/logic_axi4_stream_inject.sv
// Two-flop reset synchronizer: asserts asynchronously, releases synchronously to clk.
// Latency: deassertion reaches rst_n_sync on the second rising clk edge after rst_n rises.
// Backpressure: none (no handshake).
module logic_reset_synchronizer (
    input  logic clk,
    input  logic rst_n,
    output logic rst_n_sync
);

    logic [1:0] sync_q;
    logic [1:0] sync_d;

    // Shift a one in behind the asynchronous assertion.
    always_comb begin
        sync_d = {sync_q[0], 1'b1};
    end

    // Clear at once on reset, release one stage per clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign rst_n_sync = sync_q[1];

endmodule

// Packet-atomic 2:1 AXI4-Stream merge: rx[0] is the main stream, rx[1] carries injected packets.
// Latency: 1 cycle from rx handshake to tx_tvalid; 1 beat/cycle, no bubble between packets.
// Backpressure: rx treadys = grant gated by (!tx_tvalid || tx_tready); tx held stable while stalled.
module logic_axi4_stream_inject #(
    parameter int TDATA_BYTES = 1,
    parameter int TDEST_WIDTH = 1,
    parameter int TUSER_WIDTH = 1,
    parameter int TID_WIDTH   = 1,
    parameter int USE_TLAST   = 1,
    parameter int USE_TKEEP   = 1,
    parameter int USE_TSTRB   = 1,
    parameter int PRIORITY    = 0
) (
    input  logic                               aclk,
    input  logic                               areset_n,

    input  logic [1:0]                         rx_tvalid,
    output logic [1:0]                         rx_tready,
    input  logic [1:0][TDATA_BYTES*8-1:0]      rx_tdata,
    input  logic [1:0][TDATA_BYTES-1:0]        rx_tkeep,
    input  logic [1:0][TDATA_BYTES-1:0]        rx_tstrb,
    input  logic [1:0]                         rx_tlast,
    input  logic [1:0][TID_WIDTH-1:0]          rx_tid,
    input  logic [1:0][TDEST_WIDTH-1:0]        rx_tdest,
    input  logic [1:0][TUSER_WIDTH-1:0]        rx_tuser,

    output logic                               tx_tvalid,
    input  logic                               tx_tready,
    output logic [TDATA_BYTES*8-1:0]           tx_tdata,
    output logic [TDATA_BYTES-1:0]             tx_tkeep,
    output logic [TDATA_BYTES-1:0]             tx_tstrb,
    output logic                               tx_tlast,
    output logic [TID_WIDTH-1:0]               tx_tid,
    output logic [TDEST_WIDTH-1:0]             tx_tdest,
    output logic [TUSER_WIDTH-1:0]             tx_tuser
);

    localparam int DW = TDATA_BYTES * 8;
    localparam int KW = TDATA_BYTES;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY0 = 2'd1,
        ST_BUSY1 = 2'd2
    } state_t;

    logic                   rst_n_sync;

    state_t                 state_q,   state_d;
    logic                   ptr_q,     ptr_d;
    logic                   tx_vld_q,  tx_vld_d;
    logic [DW-1:0]          tx_data_q, tx_data_d;
    logic [KW-1:0]          tx_keep_q, tx_keep_d;
    logic [KW-1:0]          tx_strb_q, tx_strb_d;
    logic                   tx_last_q, tx_last_d;
    logic [TID_WIDTH-1:0]   tx_id_q,   tx_id_d;
    logic [TDEST_WIDTH-1:0] tx_dest_q, tx_dest_d;
    logic [TUSER_WIDTH-1:0] tx_user_q, tx_user_d;

    logic [1:0]             grant;
    logic                   adv;
    logic                   sel;
    logic                   fire;
    logic                   beat_last;

    logic_reset_synchronizer u_rst_sync (
        .clk        (aclk),
        .rst_n      (areset_n),
        .rst_n_sync (rst_n_sync)
    );

    // Grant: locked to the owner mid-packet, otherwise decided in the same cycle from tvalid.
    always_comb begin
        grant = 2'b00;
        case (state_q)
            ST_BUSY0: grant = 2'b01;
            ST_BUSY1: grant = 2'b10;
            default: begin
                case (rx_tvalid)
                    2'b01:   grant = 2'b01;
                    2'b10:   grant = 2'b10;
                    2'b11: begin
                        if (PRIORITY == 1) begin
                            grant = 2'b10;
                        end else if (PRIORITY == 2) begin
                            grant = 2'b01;
                        end else begin
                            grant = ptr_q ? 2'b10 : 2'b01;
                        end
                    end
                    default: grant = 2'b00;
                endcase
            end
        endcase
    end

    // The output register can take a beat when empty or draining this cycle.
    assign adv       = !tx_vld_q || tx_tready;
    // Held low while the synchronized reset is active so nothing is accepted then.
    assign rx_tready = grant & {2{adv && rst_n_sync}};
    assign sel       = grant[1];
    assign fire      = |(rx_tvalid & rx_tready);
    // Without tlast every beat is its own packet, so arbitration happens per beat.
    assign beat_last = (USE_TLAST > 0) ? rx_tlast[sel] : 1'b1;

    // Next state: load the granted beat, release the lock on its last beat, drain otherwise.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        tx_vld_d  = tx_vld_q;
        tx_data_d = tx_data_q;
        tx_keep_d = tx_keep_q;
        tx_strb_d = tx_strb_q;
        tx_last_d = tx_last_q;
        tx_id_d   = tx_id_q;
        tx_dest_d = tx_dest_q;
        tx_user_d = tx_user_q;
        if (fire) begin
            tx_vld_d  = 1'b1;
            tx_data_d = rx_tdata[sel];
            tx_keep_d = rx_tkeep[sel];
            tx_strb_d = rx_tstrb[sel];
            tx_last_d = beat_last;
            tx_id_d   = rx_tid[sel];
            tx_dest_d = rx_tdest[sel];
            tx_user_d = rx_tuser[sel];
            if (beat_last) begin
                state_d = ST_IDLE;
                ptr_d   = ~sel;
            end else begin
                state_d = sel ? ST_BUSY1 : ST_BUSY0;
            end
        end else if (tx_tready) begin
            tx_vld_d = 1'b0;
        end
    end

    // All state and the registered output stage, cleared asynchronously.
    always_ff @(posedge aclk or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            state_q   <= ST_IDLE;
            ptr_q     <= 1'b0;
            tx_vld_q  <= 1'b0;
            tx_data_q <= '0;
            tx_keep_q <= '0;
            tx_strb_q <= '0;
            tx_last_q <= 1'b0;
            tx_id_q   <= '0;
            tx_dest_q <= '0;
            tx_user_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            tx_vld_q  <= tx_vld_d;
            tx_data_q <= tx_data_d;
            tx_keep_q <= tx_keep_d;
            tx_strb_q <= tx_strb_d;
            tx_last_q <= tx_last_d;
            tx_id_q   <= tx_id_d;
            tx_dest_q <= tx_dest_d;
            tx_user_q <= tx_user_d;
        end
    end

    assign tx_tvalid = tx_vld_q;
    assign tx_tdata  = tx_data_q;
    assign tx_tkeep  = (USE_TKEEP > 0) ? tx_keep_q : {KW{1'b1}};
    assign tx_tstrb  = (USE_TSTRB > 0) ? tx_strb_q : {KW{1'b1}};
    assign tx_tlast  = (USE_TLAST > 0) ? tx_last_q : 1'b1;
    assign tx_tid    = tx_id_q;
    assign tx_tdest  = tx_dest_q;
    assign tx_tuser  = tx_user_q;

endmodule

// File: tb/tb_logic_axi4_stream_inject.sv
// Bench for logic_axi4_stream_inject: round-robin instance with scoreboard, plus a strict-priority instance.
// Latency: checks the 1-cycle, gapless path on directed packets.
// Backpressure: drives random and held tx_tready stalls.
module tb_logic_axi4_stream_inject;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       id;
        logic       dest;
        logic       user;
        logic       keep;
        logic       strb;
    } beat_t;

    typedef struct packed {
        logic [31:0] cyc;
        beat_t       b;
    } log_t;

    logic            aclk;
    logic            areset_n;

    logic [1:0]      rx_tvalid, rx_tready;
    logic [1:0][7:0] rx_tdata;
    logic [1:0]      rx_tkeep, rx_tstrb, rx_tlast, rx_tid, rx_tdest, rx_tuser;
    logic            tx_tvalid, tx_tready;
    logic [7:0]      tx_tdata;
    logic            tx_tkeep, tx_tstrb, tx_tlast, tx_tid, tx_tdest, tx_tuser;

    logic [1:0]      b_rx_tvalid, b_rx_tready;
    logic [1:0][7:0] b_rx_tdata;
    logic [1:0]      b_rx_tkeep, b_rx_tstrb, b_rx_tlast, b_rx_tid, b_rx_tdest, b_rx_tuser;
    logic            b_tx_tvalid, b_tx_tready;
    logic [7:0]      b_tx_tdata;
    logic            b_tx_tkeep, b_tx_tstrb, b_tx_tlast, b_tx_tid, b_tx_tdest, b_tx_tuser;

    int              checks;
    int              failures;
    int              gap_pct;
    logic [31:0]     cyc;
    beat_t           drv_q [2][$];
    beat_t           exp_q [2][$];
    log_t            log_q [$];
    logic            lock_vld;
    logic            lock_src;

    logic_axi4_stream_inject #(.PRIORITY(0)) u_dut (
        .aclk(aclk), .areset_n(areset_n),
        .rx_tvalid(rx_tvalid), .rx_tready(rx_tready), .rx_tdata(rx_tdata),
        .rx_tkeep(rx_tkeep), .rx_tstrb(rx_tstrb), .rx_tlast(rx_tlast),
        .rx_tid(rx_tid), .rx_tdest(rx_tdest), .rx_tuser(rx_tuser),
        .tx_tvalid(tx_tvalid), .tx_tready(tx_tready), .tx_tdata(tx_tdata),
        .tx_tkeep(tx_tkeep), .tx_tstrb(tx_tstrb), .tx_tlast(tx_tlast),
        .tx_tid(tx_tid), .tx_tdest(tx_tdest), .tx_tuser(tx_tuser)
    );

    logic_axi4_stream_inject #(.PRIORITY(1)) u_dut_p1 (
        .aclk(aclk), .areset_n(areset_n),
        .rx_tvalid(b_rx_tvalid), .rx_tready(b_rx_tready), .rx_tdata(b_rx_tdata),
        .rx_tkeep(b_rx_tkeep), .rx_tstrb(b_rx_tstrb), .rx_tlast(b_rx_tlast),
        .rx_tid(b_rx_tid), .rx_tdest(b_rx_tdest), .rx_tuser(b_rx_tuser),
        .tx_tvalid(b_tx_tvalid), .tx_tready(b_tx_tready), .tx_tdata(b_tx_tdata),
        .tx_tkeep(b_tx_tkeep), .tx_tstrb(b_tx_tstrb), .tx_tlast(b_tx_tlast),
        .tx_tid(b_tx_tid), .tx_tdest(b_tx_tdest), .tx_tuser(b_tx_tuser)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic beat_t tx_beat();
        beat_t b;
        b.data = tx_tdata;
        b.last = tx_tlast;
        b.id   = tx_tid;
        b.dest = tx_tdest;
        b.user = tx_tuser;
        b.keep = tx_tkeep;
        b.strb = tx_tstrb;
        return b;
    endfunction

    // Queue one packet on source s; the same beats become that source's expected output.
    task automatic push_pkt(input int s, input int len, input logic [7:0] base, input bit rnd);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.data = rnd ? 8'($urandom_range(255)) : base + 8'(i);
            b.last = (i == len - 1);
            b.id   = 1'(s);
            b.dest = rnd ? 1'($urandom_range(1)) : 1'b0;
            b.user = rnd ? 1'($urandom_range(1)) : 1'b1;
            b.keep = rnd ? 1'($urandom_range(1)) : 1'b1;
            b.strb = rnd ? 1'($urandom_range(1)) : 1'b1;
            drv_q[s].push_back(b);
            exp_q[s].push_back(b);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #2;
    endtask

    task automatic wait_log(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (log_q.size() < n && k < budget) begin
            step();
            k++;
        end
        chk({tag, "_timeout"}, log_q.size() >= n, 1);
    endtask

    // Source drivers: decide the handshake at negedge, update just after posedge, hold tvalid until taken.
    initial begin
        logic [1:0] fired;
        logic [1:0] drv_vld;
        drv_vld   = 2'b00;
        rx_tvalid = 2'b00;
        rx_tdata  = '0;
        rx_tkeep  = '0;
        rx_tstrb  = '0;
        rx_tlast  = '0;
        rx_tid    = '0;
        rx_tdest  = '0;
        rx_tuser  = '0;
        forever begin
            @(negedge aclk);
            fired = rx_tvalid & rx_tready;
            @(posedge aclk);
            #1;
            for (int s = 0; s < 2; s++) begin
                if (fired[s] && drv_q[s].size() > 0) void'(drv_q[s].pop_front());
                if (drv_q[s].size() == 0) drv_vld[s] = 1'b0;
                else if (fired[s] || !drv_vld[s]) drv_vld[s] = ($urandom_range(99) >= gap_pct);
                if (drv_q[s].size() > 0) begin
                    rx_tdata[s] = drv_q[s][0].data;
                    rx_tlast[s] = drv_q[s][0].last;
                    rx_tid[s]   = drv_q[s][0].id;
                    rx_tdest[s] = drv_q[s][0].dest;
                    rx_tuser[s] = drv_q[s][0].user;
                    rx_tkeep[s] = drv_q[s][0].keep;
                    rx_tstrb[s] = drv_q[s][0].strb;
                end
            end
            rx_tvalid = drv_vld;
        end
    end

    // Output monitor: per-source order, packet atomicity, and AXI hold while stalled.
    initial begin
        logic  hold_pend;
        beat_t hold_b;
        beat_t cur;
        beat_t e;
        log_t  le;
        int    s;
        hold_pend = 1'b0;
        lock_vld  = 1'b0;
        lock_src  = 1'b0;
        cyc       = '0;
        forever begin
            @(negedge aclk);
            cyc = cyc + 1;
            cur = tx_beat();
            if (!areset_n) begin
                lock_vld  = 1'b0;
                hold_pend = 1'b0;
            end else begin
                if (hold_pend) begin
                    chk("hold_vld", tx_tvalid, 1);
                    chk("hold_beat", cur, hold_b);
                end
                hold_pend = tx_tvalid && !tx_tready;
                hold_b    = cur;
                if (tx_tvalid && tx_tready) begin
                    s = int'(cur.id);
                    chk("sb_nonempty", exp_q[s].size() > 0, 1);
                    if (exp_q[s].size() > 0) begin
                        e = exp_q[s].pop_front();
                        chk("sb_beat", cur, e);
                    end
                    if (lock_vld) chk("atomic_src", cur.id, lock_src);
                    lock_vld = !cur.last;
                    lock_src = cur.id;
                    le.cyc = cyc;
                    le.b   = cur;
                    log_q.push_back(le);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int         k;
        int         bcnt;
        int         bout;
        logic       bfire;
        logic [7:0] exp2 [6];
        logic       last2 [6];
        checks      = 0;
        failures    = 0;
        gap_pct     = 0;
        areset_n    = 1'b0;
        tx_tready   = 1'b1;
        b_rx_tvalid = 2'b00;
        b_rx_tdata  = '0;
        b_rx_tkeep  = 2'b11;
        b_rx_tstrb  = 2'b11;
        b_rx_tlast  = 2'b00;
        b_rx_tid    = 2'b10;
        b_rx_tdest  = 2'b00;
        b_rx_tuser  = 2'b00;
        b_tx_tready = 1'b1;

        // Reset held, then released with no traffic.
        repeat (3) begin
            @(negedge aclk);
            chk("rst_tx_tvalid", tx_tvalid, 0);
            chk("rst_rx_tready", rx_tready, 0);
        end
        chk("rst_tx_tdata", tx_tdata, 0);
        step();
        areset_n = 1'b1;
        repeat (4) begin
            @(negedge aclk);
            chk("idle_rx_tready", rx_tready, 0);
            chk("idle_tx_tvalid", tx_tvalid, 0);
        end

        // Round-robin with both sources offering one-beat packets.
        step();
        log_q.delete();
        for (int i = 0; i < 4; i++) begin
            push_pkt(0, 1, 8'h60 + 8'(i), 1'b0);
            push_pkt(1, 1, 8'h70 + 8'(i), 1'b0);
        end
        @(posedge aclk);
        @(negedge aclk);
        chk("rr_first_grant", rx_tready, 2'b01);
        wait_log(8, 40, "rr");
        for (int i = 0; i < 8; i++) begin
            if (i < log_q.size()) begin
                chk("rr_tid", log_q[i].b.id, i % 2);
                chk("rr_gapless", log_q[i].cyc, log_q[0].cyc + i);
            end
        end

        // Injected packet arrives mid-packet and follows without a gap.
        step();
        log_q.delete();
        push_pkt(0, 4, 8'h10, 1'b0);
        step();
        step();
        push_pkt(1, 2, 8'hA0, 1'b0);
        exp2  = '{8'h10, 8'h11, 8'h12, 8'h13, 8'hA0, 8'hA1};
        last2 = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        wait_log(6, 40, "inj");
        for (int i = 0; i < 6; i++) begin
            if (i < log_q.size()) begin
                chk("inj_data", log_q[i].b.data, exp2[i]);
                chk("inj_last", log_q[i].b.last, last2[i]);
                chk("inj_gapless", log_q[i].cyc, log_q[0].cyc + i);
            end
        end

        // Five-cycle output stall in the middle of a packet.
        step();
        log_q.delete();
        push_pkt(0, 6, 8'h20, 1'b0);
        wait_log(2, 20, "stall_pre");
        tx_tready = 1'b0;
        repeat (5) begin
            @(negedge aclk);
            chk("stall_rx_tready", rx_tready, 0);
            chk("stall_tx_tvalid", tx_tvalid, 1);
        end
        step();
        tx_tready = 1'b1;
        wait_log(6, 30, "stall_post");
        repeat (3) step();
        chk("stall_count", log_q.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < log_q.size()) chk("stall_data", log_q[i].b.data, 8'h20 + 8'(i));
        end

        // Random traffic, gaps and backpressure against the scoreboard.
        gap_pct = 30;
        for (int c = 0; c < 600; c++) begin
            step();
            for (int s = 0; s < 2; s++) begin
                if (drv_q[s].size() < 6 && $urandom_range(99) < 25)
                    push_pkt(s, int'($urandom_range(4, 1)), 8'h00, 1'b1);
            end
            tx_tready = ($urandom_range(3) != 0);
        end
        gap_pct   = 0;
        tx_tready = 1'b1;
        k = 0;
        while ((exp_q[0].size() + exp_q[1].size() + drv_q[0].size() + drv_q[1].size()) != 0 && k < 400) begin
            step();
            k++;
        end
        chk("rnd_drain_rx0", exp_q[0].size(), 0);
        chk("rnd_drain_rx1", exp_q[1].size(), 0);

        // Reset during beat 2 of a four-beat rx[1] packet.
        step();
        log_q.delete();
        push_pkt(1, 4, 8'h30, 1'b0);
        wait_log(2, 20, "rst_pre");
        areset_n = 1'b0;
        #1;
        chk("rst_async_tvalid", tx_tvalid, 0);
        chk("rst_async_rx_tready", rx_tready, 0);
        for (int s = 0; s < 2; s++) begin
            drv_q[s].delete();
            exp_q[s].delete();
        end
        log_q.delete();
        push_pkt(0, 1, 8'h40, 1'b0);
        repeat (2) begin
            @(negedge aclk);
            chk("rst_hold_rx_tready", rx_tready, 0);
        end
        step();
        areset_n = 1'b1;
        k = 0;
        do begin
            @(negedge aclk);
            k++;
        end while (rx_tready == 2'b00 && k < 10);
        chk("post_rst_grant", rx_tready, 2'b01);
        chk("post_rst_vld", rx_tvalid, 2'b01);
        wait_log(1, 20, "post_rst");
        repeat (3) step();
        chk("post_rst_count", log_q.size(), 1);
        if (log_q.size() > 0) chk("post_rst_data", log_q[0].b.data, 8'h40);

        // Strict priority to rx[1] with both sources always offering.
        step();
        b_rx_tvalid   = 2'b11;
        b_rx_tdata[0] = 8'h55;
        b_rx_tdata[1] = 8'h00;
        b_rx_tlast    = 2'b00;
        bcnt = 0;
        bout = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge aclk);
            chk("p1_rx0_blocked", b_rx_tready[0], 0);
            bfire = b_rx_tvalid[1] && b_rx_tready[1];
            if (b_tx_tvalid && b_tx_tready) begin
                chk("p1_tid", b_tx_tid, 1);
                chk("p1_data", b_tx_tdata, bout[7:0]);
                chk("p1_last", b_tx_tlast, (bout % 3) == 2);
                bout++;
            end
            @(posedge aclk);
            #1;
            if (bfire) begin
                bcnt++;
                b_rx_tdata[1] = bcnt[7:0];
                b_rx_tlast[1] = ((bcnt % 3) == 2);
            end
            b_tx_tready = ($urandom_range(3) != 0);
        end
        chk("p1_progress", bout >= 20, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/logic_axi4_stream_inject.md
Name: logic_axi4_stream_inject

Overview:
Merges two AXI4-Stream inputs into one output with packet-atomic arbitration: rx[0] carries the main stream, rx[1] carries packets to be injected. Once a source is granted, it keeps the grant until its tlast beat is transferred, so packets are never interleaved. It sits at the re-merge point after logic_axi4_stream_extract, where processed packets rejoin the main stream. Single output register stage.

Parameters:
TDATA_BYTES, 1, bytes of tdata
TDEST_WIDTH, 1, bits of tdest
TUSER_WIDTH, 1, bits of tuser
TID_WIDTH, 1, bits of tid
USE_TLAST, 1, 0 = every beat is a one-beat packet (arbitrate per beat)
USE_TKEEP, 1, carry tkeep when >0, else tie to all-ones
USE_TSTRB, 1, carry tstrb when >0, else tie to all-ones
PRIORITY, 0, 0 = round-robin; 1 = rx[1] strict priority; 2 = rx[0] strict priority

Ports:
aclk  input  1  clock
areset_n  input  1  asynchronous active-low reset (internally synchronized with logic_reset_synchronizer; deassertion takes effect on sync output)
rx  input (logic_axi4_stream_if rx modport)  array [2] of TDATA_BYTES*8 tdata plus tkeep/tstrb/tlast/tid/tdest/tuser  input streams; tready is driven by this block
tx  output (logic_axi4_stream_if tx modport)  same field widths  merged output stream; tready is an input

Behaviour:
- State machine: IDLE, BUSY0, BUSY1. Reset -> IDLE, round-robin pointer = 0 (rx[0] preferred first), tx.tvalid = 0, all other tx fields = 0.
- Pipeline advance: adv = !tx.tvalid || tx.tready.
- rx[i].tready = grant[i] && adv. Never asserted for both inputs in the same cycle; both are 0 during reset.
- Grant in IDLE (combinational, same cycle): if exactly one rx.tvalid is high, grant that input. If both are high: PRIORITY 1 -> rx[1]; PRIORITY 2 -> rx[0]; PRIORITY 0 -> the input selected by the pointer.
- In BUSYi, grant[i] = 1 and the other grant = 0, regardless of the other input's tvalid.
- Transfer on rx[i] when rx[i].tvalid && rx[i].tready:
  - Register all fields of rx[i] into tx; tx.tvalid = 1.
  - If tlast (or USE_TLAST = 0), next state = IDLE and the pointer moves to the other input. Otherwise next state = BUSYi.
- A one-beat packet transferred from IDLE stays in IDLE.
- Latency: 1 cycle from rx handshake to tx.tvalid. Full throughput of 1 beat/cycle while tx.tready = 1, including back-to-back packets from alternating sources with no bubble.
- tx.tready = 0 with tx.tvalid = 1: hold tx stable (AXI rule) and deassert both rx treadys. State and pointer are unchanged.
- tx.tvalid deasserts only when tx handshakes and no new beat is loaded in the same cycle.
- A granted source dropping tvalid mid-packet leaves the state in BUSYi with no output bubble filling. The other source stays blocked.
- Reset mid-packet: state returns to IDLE and tx.tvalid clears immediately (asynchronous). The partial packet is lost and the output truncates without tlast. Upstream must also be reset.
- Sideband (tid, tdest, tuser, tkeep, tstrb) passes through unmodified. Disabled fields output constant all-ones (tkeep/tstrb) or 1 (tlast when USE_TLAST = 0).

Test Plan:
- Reset release, no traffic -> tx.tvalid = 0, rx[0].tready = rx[1].tready = 0 until the first rx.tvalid; then grant within the same cycle.
- rx[0] sends a 4-beat packet (tdata 0x10..0x13); rx[1] raises tvalid at beat 2 with a 2-beat packet (0xA0, 0xA1), tx.tready = 1 -> tx sequence 0x10, 0x11, 0x12, 0x13, 0xA0, 0xA1, no gaps, tlast on 0x13 and 0xA1.
- PRIORITY = 0, both inputs continuously offering 1-beat packets (tid 0 and tid 1) -> tx tid alternates 0, 1, 0, 1 starting with 0.
- PRIORITY = 1, both offering 3-beat packets continuously -> only rx[1] packets appear; rx[0].tready stays 0.
- tx.tready held 0 for 5 cycles mid-packet -> tx fields stable, rx treadys 0. After release, beats resume in order with none duplicated or dropped.
- areset_n pulsed low during beat 2 of a 4-beat rx[1] packet -> tx.tvalid = 0 immediately. After release with only rx[0] valid, rx[0] is granted within the same cycle.
